// File: rtl/weapon_attack_ctrl.sv
// Attack sequencer: turns mouse clicks into melee swings or archer shots with frame-tick
// timed swing/cooldown phases, round-robin slot allocation and merged damage events.
module weapon_attack_ctrl #(
  parameter int unsigned PROJECTILE_COUNT       = 4,
  parameter int unsigned SLOT_W                 = 2,
  parameter int unsigned MELEE_SWING_FRAMES     = 12,
  parameter int unsigned MELEE_COOLDOWN_FRAMES  = 8,
  parameter int unsigned ARCHER_COOLDOWN_FRAMES = 15,
  parameter int unsigned DMG_MELEE              = 3,
  parameter int unsigned DMG_PROJ               = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        mouse_clicked,
  input  logic [1:0]                  game_active,
  input  logic [1:0]                  char_class,
  input  logic                        alive,
  input  logic                        boss_alive,
  input  logic [PROJECTILE_COUNT-1:0] slot_busy,
  input  logic                        melee_hit,
  input  logic                        projectile_hit,
  output logic                        swing_start,
  output logic                        swing_active,
  output logic                        fire,
  output logic [SLOT_W-1:0]           fire_slot,
  output logic                        cooldown_active,
  output logic                        dmg_valid,
  output logic [3:0]                  dmg_amount
);

  localparam int unsigned CntMaxA = (MELEE_SWING_FRAMES > MELEE_COOLDOWN_FRAMES) ?
                                    MELEE_SWING_FRAMES : MELEE_COOLDOWN_FRAMES;
  localparam int unsigned CntMax  = (CntMaxA > ARCHER_COOLDOWN_FRAMES) ?
                                    CntMaxA : ARCHER_COOLDOWN_FRAMES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StSwing, StCooldown} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              click_q;
  logic [SLOT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              hit_done_q, hit_done_d;

  logic              swing_start_d, fire_d, dmg_valid_d;
  logic [SLOT_W-1:0] fire_slot_d;
  logic [3:0]        dmg_amount_d;

  logic              enable;
  logic              click_edge;
  logic              slot_found;
  logic [SLOT_W-1:0] slot_idx;
  logic [SLOT_W:0]   probe_sum;
  logic              melee_ok;
  logic [4:0]        dmg_sum;

  assign enable     = (game_active == 2'd1) & alive & ((char_class == 2'd1) | (char_class == 2'd2));
  assign click_edge = mouse_clicked & ~click_q;

  // First free slot after the last one fired, wrapping modulo PROJECTILE_COUNT.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    probe_sum  = '0;
    for (int i = 1; i <= int'(PROJECTILE_COUNT); i++) begin
      probe_sum = {1'b0, rr_ptr_q} + (SLOT_W+1)'(i);
      if (probe_sum >= (SLOT_W+1)'(PROJECTILE_COUNT)) begin
        probe_sum = probe_sum - (SLOT_W+1)'(PROJECTILE_COUNT);
      end
      if (!slot_found && !slot_busy[probe_sum[SLOT_W-1:0]]) begin
        slot_found = 1'b1;
        slot_idx   = probe_sum[SLOT_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    rr_ptr_d      = rr_ptr_q;
    hit_done_d    = hit_done_q;
    swing_start_d = 1'b0;
    fire_d        = 1'b0;
    fire_slot_d   = '0;

    if (!enable) begin
      state_d   = StIdle;
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (click_edge || pending_q) begin
            // Serviced or dropped either way; a request never waits in IDLE.
            pending_d = 1'b0;
            if (char_class == 2'd1) begin
              state_d       = StSwing;
              cnt_d         = CntW'(MELEE_SWING_FRAMES);
              swing_start_d = 1'b1;
              hit_done_d    = 1'b0;
            end else if (slot_found) begin
              state_d     = StCooldown;
              cnt_d       = CntW'(ARCHER_COOLDOWN_FRAMES);
              fire_d      = 1'b1;
              fire_slot_d = slot_idx;
              rr_ptr_d    = slot_idx;
            end
          end
        end
        StSwing: begin
          if (click_edge) pending_d = 1'b1;
          if (frame_tick) begin
            if (cnt_q == CntW'(1)) begin
              state_d = StCooldown;
              cnt_d   = CntW'(MELEE_COOLDOWN_FRAMES);
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        StCooldown: begin
          if (click_edge) pending_d = 1'b1;
          if (frame_tick) begin
            if (cnt_q == CntW'(1)) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntW'(1);
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Only the first melee overlap of each swing scores.
  always_comb begin
    melee_ok = melee_hit & (state_q == StSwing) & ~hit_done_q;
    dmg_sum  = (melee_ok ? 5'(DMG_MELEE) : 5'd0) + (projectile_hit ? 5'(DMG_PROJ) : 5'd0);
    dmg_valid_d  = (melee_ok | projectile_hit) & boss_alive & enable;
    dmg_amount_d = '0;
    if (dmg_valid_d) dmg_amount_d = (dmg_sum > 5'd15) ? 4'hF : dmg_sum[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      click_q         <= 1'b0;
      rr_ptr_q        <= '0;
      hit_done_q      <= 1'b0;
      swing_start     <= 1'b0;
      swing_active    <= 1'b0;
      fire            <= 1'b0;
      fire_slot       <= '0;
      cooldown_active <= 1'b0;
      dmg_valid       <= 1'b0;
      dmg_amount      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      click_q         <= mouse_clicked;
      rr_ptr_q        <= rr_ptr_d;
      hit_done_q      <= hit_done_d | melee_ok;
      swing_start     <= swing_start_d;
      swing_active    <= (state_d == StSwing);
      fire            <= fire_d;
      fire_slot       <= fire_slot_d;
      cooldown_active <= (state_d == StCooldown);
      dmg_valid       <= dmg_valid_d;
      dmg_amount      <= dmg_amount_d;
    end
  end

endmodule

// File: tb/tb_weapon_attack_ctrl.sv
// Directed bench for weapon_attack_ctrl: melee timing, archer round-robin, pending clicks,
// aborts and a table of damage vectors.
module tb_weapon_attack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick, mouse_clicked, alive, boss_alive, melee_hit, projectile_hit;
  logic [1:0] game_active, char_class;
  logic [3:0] slot_busy;
  logic       swing_start, swing_active, fire, cooldown_active, dmg_valid;
  logic [1:0] fire_slot;
  logic [3:0] dmg_amount;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ss  = 0;
  int base;

  typedef struct {
    logic       game;
    logic       mouse;
    logic       melee;
    logic       proj;
    logic       boss;
    logic       exp_valid;
    logic [3:0] exp_amt;
    logic       exp_swing;
  } dmg_vec_t;

  dmg_vec_t vec[11];

  weapon_attack_ctrl #(
    .PROJECTILE_COUNT(4), .SLOT_W(2), .MELEE_SWING_FRAMES(12), .MELEE_COOLDOWN_FRAMES(8),
    .ARCHER_COOLDOWN_FRAMES(15), .DMG_MELEE(3), .DMG_PROJ(1)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_clicked(mouse_clicked),
    .game_active(game_active), .char_class(char_class), .alive(alive),
    .boss_alive(boss_alive), .slot_busy(slot_busy), .melee_hit(melee_hit),
    .projectile_hit(projectile_hit), .swing_start(swing_start), .swing_active(swing_active),
    .fire(fire), .fire_slot(fire_slot), .cooldown_active(cooldown_active),
    .dmg_valid(dmg_valid), .dmg_amount(dmg_amount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (swing_start) n_ss <= n_ss + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic click();
    mouse_clicked = 1'b1;
    cyc();
    mouse_clicked = 1'b0;
    cyc();
  endtask

  task automatic shot(input string name, input logic [3:0] busy, input logic exp_fire,
                      input logic [1:0] exp_slot);
    slot_busy     = busy;
    mouse_clicked = 1'b1;
    cyc();
    chk({name, " fire"}, int'(fire), int'(exp_fire));
    if (exp_fire) chk({name, " slot"}, int'(fire_slot), int'(exp_slot));
    chk({name, " cooldown"}, int'(cooldown_active), int'(exp_fire));
    mouse_clicked = 1'b0;
    cyc();
    chk({name, " fire pulse"}, int'(fire), 0);
    if (exp_fire) begin
      run_ticks(14);
      chk({name, " cd tick14"}, int'(cooldown_active), 1);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk({name, " cd tick15"}, int'(cooldown_active), 0);
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0; mouse_clicked = 1'b0; alive = 1'b0; boss_alive = 1'b0;
    melee_hit = 1'b0; projectile_hit = 1'b0; game_active = 2'd0; char_class = 2'd0;
    slot_busy = 4'b0000;

    // game, mouse, melee, proj, boss, exp_valid, exp_amt, exp_swing
    vec[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1};
    vec[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0};
    vec[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1};
    vec[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst swing_start", int'(swing_start), 0);
    chk("rst swing_active", int'(swing_active), 0);
    chk("rst fire", int'(fire), 0);
    chk("rst fire_slot", int'(fire_slot), 0);
    chk("rst cooldown", int'(cooldown_active), 0);
    chk("rst dmg_valid", int'(dmg_valid), 0);
    chk("rst dmg_amount", int'(dmg_amount), 0);
    rst = 1'b0;

    // Melee: entry tick coincides with the click and must not count.
    game_active = 2'd1; char_class = 2'd1; alive = 1'b1; boss_alive = 1'b1;
    repeat (7) cyc();
    mouse_clicked = 1'b1;
    frame_tick    = 1'b1;
    cyc();
    chk("melee swing_start", int'(swing_start), 1);
    chk("melee swing_active", int'(swing_active), 1);
    chk("melee no cooldown", int'(cooldown_active), 0);
    mouse_clicked = 1'b0;
    frame_tick    = 1'b0;
    cyc();
    chk("melee start pulse", int'(swing_start), 0);
    for (int i = 1; i <= 12; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("melee swing tick", int'(swing_active), int'(i < 12));
      cyc();
    end
    chk("melee cooldown entry", int'(cooldown_active), 1);
    for (int i = 1; i <= 8; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("melee cooldown tick", int'(cooldown_active), int'(i < 8));
      cyc();
    end
    chk("melee idle no restart", int'(swing_start), 0);

    // Archer round-robin allocation.
    char_class = 2'd2;
    shot("rr1", 4'b0000, 1'b1, 2'd1);
    shot("rr2", 4'b0000, 1'b1, 2'd2);
    shot("rr3", 4'b0000, 1'b1, 2'd3);
    shot("rr0", 4'b0000, 1'b1, 2'd0);
    shot("rr1b", 4'b0000, 1'b1, 2'd1);
    shot("skip busy", 4'b0100, 1'b1, 2'd3);
    shot("all busy", 4'b1111, 1'b0, 2'd0);
    slot_busy = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dropped stays dropped", int'(fire), 0);
    end
    shot("slot0 free", 4'b1110, 1'b1, 2'd0);
    slot_busy = 4'b0000;

    // Pending: two clicks in SWING give exactly one extra swing after a 1-cycle IDLE gap.
    char_class = 2'd1;
    base = n_ss;
    click();
    run_ticks(2);
    click();
    run_ticks(2);
    click();
    run_ticks(8);
    chk("pend cooldown", int'(cooldown_active), 1);
    run_ticks(7);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("pend idle gap cd", int'(cooldown_active), 0);
    chk("pend idle gap start", int'(swing_start), 0);
    cyc();
    chk("pend serviced start", int'(swing_start), 1);
    chk("pend serviced active", int'(swing_active), 1);
    run_ticks(12);
    run_ticks(8);
    repeat (3) cyc();
    chk("pend swing count", n_ss - base, 2);
    chk("pend final idle", int'(swing_active), 0);

    // Abort mid-swing with counter at 5 and a pending click.
    base = n_ss;
    click();
    run_ticks(7);
    click();
    alive = 1'b0;
    cyc();
    chk("abort swing_active", int'(swing_active), 0);
    chk("abort cooldown", int'(cooldown_active), 0);
    chk("abort swing_start", int'(swing_start), 0);
    chk("abort fire", int'(fire), 0);
    alive = 1'b1;
    repeat (6) cyc();
    chk("abort pending cleared", int'(swing_active), 0);
    chk("abort swing count", n_ss - base, 1);

    // Asynchronous reset in COOLDOWN.
    click();
    run_ticks(14);
    chk("pre-rst cooldown", int'(cooldown_active), 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst cooldown", int'(cooldown_active), 0);
    chk("async rst swing", int'(swing_active), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Damage table; first starts a swing.
    mouse_clicked = 1'b1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      game_active    = {1'b0, vec[i].game};
      mouse_clicked  = vec[i].mouse;
      melee_hit      = vec[i].melee;
      projectile_hit = vec[i].proj;
      boss_alive     = vec[i].boss;
      cyc();
      chk($sformatf("dmg[%0d] valid", i), int'(dmg_valid), int'(vec[i].exp_valid));
      if (vec[i].exp_valid) begin
        chk($sformatf("dmg[%0d] amount", i), int'(dmg_amount), int'(vec[i].exp_amt));
      end
      chk($sformatf("dmg[%0d] swing", i), int'(swing_active), int'(vec[i].exp_swing));
    end
    melee_hit = 1'b0; projectile_hit = 1'b0; mouse_clicked = 1'b0;
    cyc();
    chk("dmg quiet", int'(dmg_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
